// File: rtl/apu_ctrl_sequencer.sv
// Command sequencer for the apu_pulse channels: buffers period/duty writes in a
// FIFO and dispatches them in order to per-channel valid/ready register ports.
module apu_ctrl_sequencer #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_W   = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  cmd_r,
  input  logic                         cmd_r_vld,
  output logic                         cmd_r_rdy,
  output logic [NUM_CH*PERIOD_W-1:0]   period_s,
  output logic [NUM_CH-1:0]            period_s_vld,
  input  logic [NUM_CH-1:0]            period_s_rdy,
  output logic [NUM_CH*2-1:0]          duty_s,
  output logic [NUM_CH-1:0]            duty_s_vld,
  input  logic [NUM_CH-1:0]            duty_s_rdy,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t state, state_nxt;

  // Entries keep only channel, field and value; reserved bits are discarded at push.
  logic [13:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;
  logic                full, empty, push, pop;

  logic [13:0]         head;
  logic [1:0]          hd_ch;
  logic                hd_fld;
  logic [PERIOD_W-1:0] hd_period;
  logic [1:0]          hd_duty;
  logic [NUM_CH-1:0]   hd_mask;
  logic                issue_p, issue_d, all_done;
  logic                unused_rsv;

  assign unused_rsv = ^cmd_r[12:11];

  assign full       = (count == LW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign cmd_r_rdy  = !full;
  assign push       = cmd_r_vld && !full;
  assign fifo_level = count;
  assign busy       = !empty || (state == ST_WAIT);

  assign head      = mem[rd_ptr];
  assign hd_ch     = head[13:12];
  assign hd_fld    = head[11];
  assign hd_period = PERIOD_W'(head[10:0]);
  assign hd_duty   = head[1:0];

  always_comb begin
    hd_mask = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (hd_ch == 2'(c)) hd_mask[c] = 1'b1;
    end
    if (hd_ch == 2'd3) hd_mask = '1;
  end

  // A command may issue once every bit still pending has its handshake on this edge.
  assign all_done = ~|{period_s_vld & ~period_s_rdy, duty_s_vld & ~duty_s_rdy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue_p || issue_d) state_nxt = ST_WAIT;
      ST_WAIT: if (all_done) state_nxt = (issue_p || issue_d) ? ST_WAIT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    issue_p = 1'b0;
    issue_d = 1'b0;
    if (!empty && (state == ST_IDLE || all_done)) begin
      pop = 1'b1;
      if (|hd_mask) begin
        issue_p = !hd_fld;
        issue_d = hd_fld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_r[15:13], cmd_r[10:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_s_vld <= '0;
      duty_s_vld   <= '0;
      period_s     <= '0;
      duty_s       <= '0;
    end else begin
      period_s_vld <= (period_s_vld & ~period_s_rdy) | (issue_p ? hd_mask : '0);
      duty_s_vld   <= (duty_s_vld & ~duty_s_rdy) | (issue_d ? hd_mask : '0);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (issue_p && hd_mask[c]) period_s[c*PERIOD_W +: PERIOD_W] <= hd_period;
        if (issue_d && hd_mask[c]) duty_s[c*2 +: 2] <= hd_duty;
      end
    end
  end

endmodule
